// File: rtl/rv32e_dbus_pkg.sv
// rtl/rv32e_dbus_pkg.sv - RV32E data-bus address map, UART STATUS bit positions and serializer states
package rv32e_dbus_pkg;

  localparam logic [31:0] DBUS_MMIO_BASE   = 32'h8000_0000;
  localparam logic [31:0] DBUS_UART_DATA   = DBUS_MMIO_BASE + 32'h0;
  localparam logic [31:0] DBUS_UART_STATUS = DBUS_MMIO_BASE + 32'h4;
  localparam logic [31:0] DBUS_TIMER       = DBUS_MMIO_BASE + 32'h8;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;
  localparam int ST_CNT_W   = 4;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/rv32e_uart_tx.sv
// rtl/rv32e_uart_tx.sv - 8N1 serializer: pops one byte when idle, shifts it out LSB first
module rv32e_uart_tx
  import rv32e_dbus_pkg::*;
#(
  parameter int CLK_DIV = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       pop,
  output logic       busy,
  output logic       tx
);

  localparam int BW = $clog2(CLK_DIV);

  uart_state_e r_state, w_state_nxt;
  logic [BW-1:0] r_baud, w_baud_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          w_baud_done;

  assign w_baud_done = (r_baud == BW'(CLK_DIV - 1));
  assign busy        = (r_state != UART_IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= UART_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // tx is decoded from state so a reset forces the line high on the very next edge
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    pop         = 1'b0;
    tx          = 1'b1;
    case (r_state)
      UART_IDLE: begin
        if (valid) begin
          pop         = 1'b1;
          w_shift_nxt = data;
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = UART_START;
        end
      end
      UART_START: begin
        tx = 1'b0;
        if (w_baud_done) begin
          w_baud_nxt  = '0;
          w_state_nxt = UART_DATA;
        end else begin
          w_baud_nxt = r_baud + BW'(1);
        end
      end
      UART_DATA: begin
        tx = r_shift[0];
        if (w_baud_done) begin
          w_baud_nxt  = '0;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_bit_nxt   = '0;
            w_state_nxt = UART_STOP;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end else begin
          w_baud_nxt = r_baud + BW'(1);
        end
      end
      UART_STOP: begin
        if (w_baud_done) begin
          w_baud_nxt  = '0;
          w_state_nxt = UART_IDLE;
        end else begin
          w_baud_nxt = r_baud + BW'(1);
        end
      end
      default: w_state_nxt = UART_IDLE;
    endcase
  end

endmodule

// File: rtl/rv32e_data_bus.sv
// rtl/rv32e_data_bus.sv - RV32E data-side bus: word RAM, UART TX FIFO, cycle timer (RV32E_DBUS_TIMER_EN)
module rv32e_data_bus
  import rv32e_dbus_pkg::*;
#(
  parameter int RAM_WORDS  = 256,
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr_bus,
  input  logic [31:0] mem_write_data_bus,
  input  logic        mem_write_signal,
  output logic [31:0] mem_read_data_bus,
  output logic        uart_tx
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]   r_ram [RAM_WORDS];
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_rd_ptr, r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic [31:0]   w_word_addr;
  logic [AW-1:0] w_ram_idx;
  logic          w_is_ram, w_is_udata, w_is_status;
  logic          w_push_req, w_push_ok, w_pop;
  logic          w_fifo_full, w_fifo_empty, w_busy;
  logic [31:0]   w_status;

  // Masking keeps every address bit in the decode while ignoring the byte offset
  assign w_word_addr = mem_addr_bus & 32'hFFFF_FFFC;
  assign w_ram_idx   = mem_addr_bus[AW+1:2];
  assign w_is_ram    = (mem_addr_bus[31:AW+2] == '0);
  assign w_is_udata  = (w_word_addr == DBUS_UART_DATA);
  assign w_is_status = (w_word_addr == DBUS_UART_STATUS);

  assign w_fifo_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_fifo_empty = (r_count == '0);
  assign w_push_req   = mem_write_signal && w_is_udata;
  assign w_push_ok    = w_push_req && (!w_fifo_full || w_pop);

  always_ff @(posedge clk) begin
    if (mem_write_signal && w_is_ram) begin
      r_ram[w_ram_idx] <= mem_write_data_bus;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_fifo[r_wr_ptr] <= mem_write_data_bus[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_push_req && !w_push_ok) begin
        r_overflow <= 1'b1;
      end else if (mem_write_signal && w_is_status && mem_write_data_bus[ST_OVF]) begin
        r_overflow <= 1'b0;
      end
    end
  end

  rv32e_uart_tx #(
    .CLK_DIV(CLK_DIV)
  ) u_uart_tx (
    .clk  (clk),
    .reset(reset),
    .valid(!w_fifo_empty),
    .data (r_fifo[r_rd_ptr]),
    .pop  (w_pop),
    .busy (w_busy),
    .tx   (uart_tx)
  );

  always_comb begin
    w_status                          = '0;
    w_status[ST_BUSY]                 = w_busy;
    w_status[ST_FULL]                 = w_fifo_full;
    w_status[ST_EMPTY]                = w_fifo_empty;
    w_status[ST_OVF]                  = r_overflow;
    w_status[ST_CNT_LSB +: ST_CNT_W]  = ST_CNT_W'(r_count);
  end

`ifdef RV32E_DBUS_TIMER_EN
  logic [31:0] r_timer;
  logic        w_is_timer;

  assign w_is_timer = (w_word_addr == DBUS_TIMER);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_timer <= '0;
    end else if (mem_write_signal && w_is_timer) begin
      r_timer <= mem_write_data_bus;
    end else begin
      r_timer <= r_timer + 32'd1;
    end
  end
`endif

  always_comb begin
    mem_read_data_bus = '0;
    if (w_is_ram) begin
      mem_read_data_bus = r_ram[w_ram_idx];
    end else if (w_is_status) begin
      mem_read_data_bus = w_status;
    end
`ifdef RV32E_DBUS_TIMER_EN
    else if (w_is_timer) begin
      mem_read_data_bus = r_timer;
    end
`endif
  end

endmodule

// File: tb/tb_rv32e_data_bus.sv
// tb/tb_rv32e_data_bus.sv - directed vector bench for rv32e_data_bus (RAM, UART frames, overflow, timer, reset)
module tb_rv32e_data_bus;

  localparam int CLK_DIV = 4;
  localparam logic [31:0] A_UDATA  = 32'h8000_0000;
  localparam logic [31:0] A_STATUS = 32'h8000_0004;
  localparam logic [31:0] A_TIMER  = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] mem_addr_bus = '0;
  logic [31:0] mem_write_data_bus = '0;
  logic        mem_write_signal = 1'b0;
  logic [31:0] mem_read_data_bus;
  logic        uart_tx;

  int total = 0;
  int bad = 0;

  rv32e_data_bus #(
    .RAM_WORDS (256),
    .CLK_DIV   (CLK_DIV),
    .FIFO_DEPTH(4)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .mem_addr_bus      (mem_addr_bus),
    .mem_write_data_bus(mem_write_data_bus),
    .mem_write_signal  (mem_write_signal),
    .mem_read_data_bus (mem_read_data_bus),
    .uart_tx           (uart_tx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    mem_addr_bus       = a;
    mem_write_data_bus = d;
    mem_write_signal   = 1'b1;
    tick();
    mem_write_signal   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    mem_addr_bus = a;
    #1;
    d = mem_read_data_bus;
  endtask

  logic [31:0] d;
  logic [39:0] act_frame, exp_frame;
  logic [31:0] status_mid;
  logic [7:0]  b55;
  logic [7:0]  rx_bytes[8];
  logic [7:0]  exp_bytes[5];
  int          nrx;
  int          stop_err;
  int          low_cycles;
  logic [31:0] exp_timer[3];

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b0, 32'h0000_0400, 32'h0,         1'b1, 32'h0};
    vecs[4]  = '{1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 32'h0000_0400, 32'h1111_2222, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'hA5A5_A5A5};
    vecs[7]  = '{1'b1, 32'h0000_03FC, 32'h1234_5678, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 32'h0000_03FF, 32'h0,         1'b1, 32'h1234_5678};
    vecs[9]  = '{1'b0, A_UDATA,       32'h0,         1'b1, 32'h0};
    vecs[10] = '{1'b0, 32'h8000_000C, 32'h0,         1'b1, 32'h0};
    vecs[11] = '{1'b0, A_STATUS,      32'h0,         1'b1, 32'h0000_0004};
    vecs[12] = '{1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 1'b0, 32'h0};
    vecs[13] = '{1'b0, A_STATUS,      32'h0,         1'b1, 32'h0000_0004};
    vecs[14] = '{1'b0, 32'h4000_0010, 32'h0,         1'b1, 32'h0};
    vecs[15] = '{1'b1, A_STATUS,      32'hFFFF_FFF7, 1'b0, 32'h0};
    vecs[16] = '{1'b0, A_STATUS,      32'h0,         1'b1, 32'h0000_0004};

    // reset state
    repeat (3) tick();
    check("rst_tx", 64'(uart_tx), 64'd1);
    rd(A_STATUS, d);
    check("rst_status", 64'(d), 64'h4);
    rd(A_TIMER, d);
    check("rst_timer", 64'(d), 64'h0);
    reset = 1'b1;
    tick();

    // table-driven RAM / decode vectors
    for (int i = 0; i < 17; i++) begin
      mem_addr_bus       = vecs[i].addr;
      mem_write_data_bus = vecs[i].wdata;
      mem_write_signal   = vecs[i].we;
      #1;
      if (vecs[i].chk) check($sformatf("vec%0d", i), 64'(mem_read_data_bus), 64'(vecs[i].exp));
      tick();
      mem_write_signal = 1'b0;
    end

    // single 0x55 frame, bit-exact timing
    b55 = 8'h55;
    for (int i = 0; i < 40; i++) begin
      if (i < 4)       exp_frame[i] = 1'b0;
      else if (i < 36) exp_frame[i] = b55[(i - 4) / 4];
      else             exp_frame[i] = 1'b1;
    end
    wr(A_UDATA, 32'h55);
    mem_addr_bus = A_STATUS;
    status_mid = '0;
    for (int i = 0; i < 40; i++) begin
      tick();
      act_frame[i] = uart_tx;
      if (i == 20) status_mid = mem_read_data_bus;
    end
    check("frame55", 64'(act_frame), 64'(exp_frame));
    check("status_busy", 64'(status_mid), 64'h5);
    tick();
    check("idle_tx", 64'(uart_tx), 64'd1);
    rd(A_STATUS, d);
    check("status_after", 64'(d), 64'h4);

    // overflow: six back-to-back pushes, five frames expected
    exp_bytes[0] = 8'h11; exp_bytes[1] = 8'h22; exp_bytes[2] = 8'h33;
    exp_bytes[3] = 8'h44; exp_bytes[4] = 8'h55;
    nrx = 0;
    stop_err = 0;
    fork
      begin
        for (int k = 0; k < 6; k++) wr(A_UDATA, 32'((k + 1) * 8'h11));
        rd(A_STATUS, d);
        check("status_ovf", 64'(d), 64'h4B);
        wr(A_STATUS, 32'h08);
        rd(A_STATUS, d);
        check("status_clr", 64'(d), 64'h43);
      end
      begin
        int cyc;
        logic [7:0] rb;
        cyc = 0;
        while (cyc < 300) begin
          tick();
          cyc++;
          if (uart_tx == 1'b0) begin
            for (int k = 0; k < 8; k++) begin
              repeat (CLK_DIV) tick();
              rb[k] = uart_tx;
            end
            repeat (CLK_DIV) tick();
            if (uart_tx !== 1'b1) stop_err++;
            cyc += 9 * CLK_DIV;
            if (nrx < 8) rx_bytes[nrx] = rb;
            nrx++;
          end
        end
      end
    join
    check("frame_count", 64'(nrx), 64'd5);
    check("stop_bits", 64'(stop_err), 64'd0);
    for (int k = 0; k < 5; k++) check($sformatf("rx_byte%0d", k), 64'(rx_bytes[k]), 64'(exp_bytes[k]));

    // timer load and wrap
`ifdef RV32E_DBUS_TIMER_EN
    exp_timer[0] = 32'hFFFF_FFFE; exp_timer[1] = 32'hFFFF_FFFF; exp_timer[2] = 32'h0;
`else
    exp_timer[0] = 32'h0; exp_timer[1] = 32'h0; exp_timer[2] = 32'h0;
`endif
    wr(A_TIMER, 32'hFFFF_FFFE);
    for (int k = 0; k < 3; k++) begin
      rd(A_TIMER, d);
      check($sformatf("timer%0d", k), 64'(d), 64'(exp_timer[k]));
      tick();
    end

    // reset during data bit 3 with a second byte queued
    wr(A_UDATA, 32'hA5);
    wr(A_UDATA, 32'h3C);
    repeat (17) tick();
    check("pre_rst_bit3", 64'(uart_tx), 64'd0);
    reset = 1'b0;
    tick();
    check("mid_rst_tx", 64'(uart_tx), 64'd1);
    rd(A_STATUS, d);
    check("mid_rst_status", 64'(d), 64'h4);
    rd(A_TIMER, d);
    check("mid_rst_timer", 64'(d), 64'h0);
    tick();
    reset = 1'b1;
    low_cycles = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (uart_tx !== 1'b1) low_cycles++;
    end
    check("no_residual", 64'(low_cycles), 64'd0);
    rd(A_STATUS, d);
    check("post_rst_status", 64'(d), 64'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
